// File: rtl/console_pkg.sv
// Shared types and constants for the text console fetch path.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISP_RD,
    HOST_RD
  } rd_owner_t;

  localparam int unsigned CELL_W   = 16;
  localparam int unsigned CP_LSB   = 0;
  localparam int unsigned CP_MSB   = 7;
  localparam int unsigned ATTR_LSB = 8;
  localparam int unsigned ATTR_MSB = 15;

  typedef struct packed {
    logic [7:0] attribute;
    logic [7:0] codepoint;
  } cell_t;

  localparam logic [CELL_W-1:0] BLANK_CELL = 16'h0000;

endpackage

// File: rtl/console_addrgen.sv
// Beam-position decode: fetch slot timing, fetch address and output load strobes.
module console_addrgen #(
  parameter int unsigned BIT_WIDTH   = 12,
  parameter int unsigned BIT_HEIGHT  = 11,
  parameter int unsigned FONT_WIDTH  = 8,
  parameter int unsigned FONT_HEIGHT = 16,
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned ADDR_WIDTH  = 12
) (
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  output logic                  fetch_slot,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  load_strobe,
  output logic                  blank_strobe
);

  localparam int unsigned VIS    = COLS * FONT_WIDTH;
  localparam int unsigned FW_LOG = $clog2(FONT_WIDTH);
  localparam int unsigned FH_LOG = $clog2(FONT_HEIGHT);

  logic [31:0] cx_w, cy_w, h, next_y, row_cur, row_next, f_row, f_col;
  logic        inline_slot, line_slot;

  // In-line slots fetch the next column mid-cell; the line slot fetches column 0 of the next line.
  always_comb begin
    cx_w         = 32'(cx);
    cy_w         = 32'(cy);
    h            = cx_w & 32'(FONT_WIDTH - 1);
    next_y       = (cy_w == 32'(V_TOTAL - 1)) ? 32'd0 : cy_w + 32'd1;
    row_cur      = cy_w >> FH_LOG;
    row_next     = next_y >> FH_LOG;
    inline_slot  = (cx_w < 32'(VIS - FONT_WIDTH)) && (h == 32'(FONT_WIDTH / 2));
    line_slot    = (cx_w == 32'(H_TOTAL - 4));
    f_row        = inline_slot ? row_cur : row_next;
    f_col        = inline_slot ? (cx_w >> FW_LOG) + 32'd1 : 32'd0;
    fetch_slot   = inline_slot || line_slot;
    fetch_valid  = (f_row < 32'(ROWS));
    fetch_addr   = ADDR_WIDTH'(f_row * 32'(COLS) + f_col);
    load_strobe  = ((h == 32'(FONT_WIDTH - 1)) && (cx_w < 32'(VIS - 1))) ||
                   (cx_w == 32'(H_TOTAL - 1));
    blank_strobe = (cx_w == 32'(VIS - 1));
  end

endmodule

// File: rtl/console_fetch.sv
// Character RAM scheduler: display prefetch has fixed-slot priority, host takes the rest.
module console_fetch
  import console_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 12,
  parameter int unsigned BIT_HEIGHT  = 11,
  parameter int unsigned FONT_WIDTH  = 8,
  parameter int unsigned FONT_HEIGHT = 16,
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned ADDR_WIDTH  = 12
) (
  input  logic                  clk_pixel,
  input  logic                  rst,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  output logic [7:0]            codepoint,
  output logic [7:0]            attribute,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [15:0]           host_wdata,
  output logic                  host_ready,
  output logic [15:0]           host_rdata,
  output logic                  host_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  logic                  fetch_slot, fetch_valid, load_strobe, blank_strobe;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  disp_rd, host_acc;

  rd_owner_t state_q, state_d;
  cell_t     staging_q, staging_d;
  cell_t     cell_q, cell_d;

  console_addrgen #(
    .BIT_WIDTH  (BIT_WIDTH),
    .BIT_HEIGHT (BIT_HEIGHT),
    .FONT_WIDTH (FONT_WIDTH),
    .FONT_HEIGHT(FONT_HEIGHT),
    .COLS       (COLS),
    .ROWS       (ROWS),
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addrgen (
    .cx          (cx),
    .cy          (cy),
    .fetch_slot  (fetch_slot),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .load_strobe (load_strobe),
    .blank_strobe(blank_strobe)
  );

  // Arbitration and RAM port drive; blank-row slots leave the RAM free for the host.
  always_comb begin
    disp_rd    = fetch_slot && fetch_valid && !rst;
    host_acc   = host_req && !disp_rd && !rst;
    host_ready = host_acc;
    mem_en     = disp_rd || host_acc;
    mem_we     = host_acc && host_we;
    mem_addr   = disp_rd ? fetch_addr : host_addr;
    mem_wdata  = host_wdata;
  end

  // Read-owner tracking, staging capture and output loads.
  always_comb begin
    state_d   = IDLE;
    staging_d = staging_q;
    cell_d    = cell_q;
    if (disp_rd) begin
      state_d = DISP_RD;
    end else if (host_acc && !host_we) begin
      state_d = HOST_RD;
    end
    if (fetch_slot && !fetch_valid) begin
      staging_d = cell_t'(BLANK_CELL);
    end
    if (state_q == DISP_RD) begin
      staging_d = cell_t'(mem_rdata);
    end
    if (blank_strobe) begin
      cell_d = cell_t'(BLANK_CELL);
    end else if (load_strobe) begin
      cell_d = staging_q;
    end
  end

  // Read data returns while the owner is HOST_RD; a reset in that cycle drops it.
  always_comb begin
    host_rvalid = (state_q == HOST_RD) && !rst;
    host_rdata  = host_rvalid ? mem_rdata : 16'h0000;
    codepoint   = cell_q.codepoint;
    attribute   = cell_q.attribute;
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_q   <= IDLE;
      staging_q <= cell_t'(BLANK_CELL);
      cell_q    <= cell_t'(BLANK_CELL);
    end else begin
      state_q   <= state_d;
      staging_q <= staging_d;
      cell_q    <= cell_d;
    end
  end

endmodule
